// File: rtl/sqr_gen_pkg.sv
// Shared constants, reset defaults and the configuration record for the DDS square generator.
// Config fields are sized for the largest supported build (ACC_W<=32, PHASE_W/AMP_W<=16, NCH<=8).
package sqr_gen_pkg;

    localparam int CFG_MAX_NCH    = 8;
    localparam int CFG_FREQ_MAX_W = 32;
    localparam int CFG_RES_MAX_W  = 16;

    typedef struct packed {
        logic [CFG_FREQ_MAX_W-1:0]                  freq;
        logic [CFG_RES_MAX_W-1:0]                   duty;
        logic [CFG_RES_MAX_W-1:0]                   amp;
        logic [CFG_MAX_NCH-1:0][CFG_RES_MAX_W-1:0]  phase;
    } sqr_cfg_t;

    // DAC midscale for a given word width.
    function automatic logic [31:0] mid_of(input int dac_w);
        return 32'(1) << (dac_w - 1);
    endfunction

    // Power-on configuration: stopped, 50% duty, zero amplitude, no phase offsets.
    function automatic sqr_cfg_t cfg_reset(input int phase_w);
        sqr_cfg_t c;
        c      = '0;
        c.duty = CFG_RES_MAX_W'(1) << (phase_w - 1);
        return c;
    endfunction

endpackage

// File: rtl/sqr_chan.sv
// One output channel: stage 1 phase-offset compare against duty, stage 2 DAC level select.
module sqr_chan
    import sqr_gen_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int DAC_W   = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_acc_top,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [PHASE_W-1:0] i_duty,
    input  logic [DAC_W-1:0]   i_half,
    output logic [DAC_W-1:0]   o_da
);

    localparam logic [DAC_W-1:0] MID = DAC_W'(mid_of(DAC_W));

    logic [PHASE_W-1:0] w_p;
    logic               r_hi;
    logic               r_vld;

    assign w_p = i_acc_top + i_phase;

    // r_vld keeps the flushed stage-1 slot from producing a level right after enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= 1'b0;
            r_vld <= 1'b0;
            o_da  <= '0;
        end else if (!i_en) begin
            r_hi  <= 1'b0;
            r_vld <= 1'b0;
            o_da  <= '0;
        end else begin
            r_hi  <= (w_p < i_duty);
            r_vld <= 1'b1;
            if (r_vld) begin
                o_da <= r_hi ? (MID + i_half) : (MID - i_half);
            end else begin
                o_da <= '0;
            end
        end
    end

endmodule

// File: rtl/sqr_dds_gen.sv
// N-channel DDS square/pulse generator: shared phase accumulator, per-channel phase offsets.
// Define SQR_CFG_SHADOW_EN to defer config updates to the next accumulator wrap.
module sqr_dds_gen
    import sqr_gen_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ACC_W   = 32,
    parameter int FREQ_W  = 24,
    parameter int PHASE_W = 8,
    parameter int AMP_W   = 8,
    parameter int DAC_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   cfg_we,
    input  logic [FREQ_W-1:0]      freq,
    input  logic [PHASE_W-1:0]     duty,
    input  logic [AMP_W-1:0]       amp,
    input  logic [NCH*PHASE_W-1:0] phase,
    output logic                   cfg_ack,
    output logic                   sync,
    output logic [NCH*DAC_W-1:0]   da_out
);

    localparam int               PROD_W = DAC_W + AMP_W;
    localparam logic [DAC_W-1:0] MID_M1 = DAC_W'(mid_of(DAC_W) - 32'd1);

    sqr_cfg_t           w_new_cfg;
    sqr_cfg_t           r_act;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_carry;
    logic               r_wrap;
    logic               r_sync1;
    logic [PROD_W-1:0]  w_prod;
    logic [DAC_W-1:0]   w_half;

    always_comb begin
        w_new_cfg      = '0;
        w_new_cfg.freq = CFG_FREQ_MAX_W'(freq);
        w_new_cfg.duty = CFG_RES_MAX_W'(duty);
        w_new_cfg.amp  = CFG_RES_MAX_W'(amp);
        for (int c = 0; c < NCH; c++) begin
            w_new_cfg.phase[c] = CFG_RES_MAX_W'(phase[c*PHASE_W +: PHASE_W]);
        end
    end

    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, r_act.freq[ACC_W-1:0]};

    // r_wrap travels with the accumulator value so sync lines up with that sample at da_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_wrap  <= 1'b0;
            r_sync1 <= 1'b0;
            sync    <= 1'b0;
        end else if (!en) begin
            r_acc   <= '0;
            r_wrap  <= 1'b0;
            r_sync1 <= 1'b0;
            sync    <= 1'b0;
        end else begin
            r_acc   <= w_acc_sum;
            r_wrap  <= w_carry;
            r_sync1 <= r_wrap;
            sync    <= r_sync1;
        end
    end

`ifdef SQR_CFG_SHADOW_EN
    sqr_cfg_t r_shd;
    logic     r_pend;
    logic     w_load;
    logic     w_cfg_unused;

    // A write landing on the wrap edge is not pending yet, so it waits for the following wrap.
    assign w_load = r_pend & (w_carry | ~en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act   <= cfg_reset(PHASE_W);
            r_shd   <= cfg_reset(PHASE_W);
            r_pend  <= 1'b0;
            cfg_ack <= 1'b0;
        end else begin
            if (w_load) begin
                r_act <= r_shd;
            end
            if (cfg_we) begin
                r_shd <= w_new_cfg;
            end
            r_pend  <= cfg_we | (r_pend & ~w_load);
            cfg_ack <= w_load;
        end
    end

    assign w_cfg_unused = ^{r_act, r_shd};
`else
    logic w_cfg_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act   <= cfg_reset(PHASE_W);
            cfg_ack <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_act <= w_new_cfg;
            end
            cfg_ack <= cfg_we;
        end
    end

    assign w_cfg_unused = ^r_act;
`endif

    // Half-swing rounded to nearest: full-scale amp gives levels 16351/33 on a 14-bit DAC.
    assign w_prod = PROD_W'(MID_M1) * PROD_W'(r_act.amp[AMP_W-1:0])
                  + (PROD_W'(1) << (AMP_W - 1));
    assign w_half = w_prod[PROD_W-1:AMP_W];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            sqr_chan #(
                .PHASE_W (PHASE_W),
                .DAC_W   (DAC_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_en      (en),
                .i_acc_top (r_acc[ACC_W-1 -: PHASE_W]),
                .i_phase   (r_act.phase[gi][PHASE_W-1:0]),
                .i_duty    (r_act.duty[PHASE_W-1:0]),
                .i_half    (w_half),
                .o_da      (da_out[gi*DAC_W +: DAC_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sqr_dds_gen.sv
// Directed self-checking bench for sqr_dds_gen (NCH=2, 32-bit tuning word so 2^24/2^25 fit).
`timescale 1ns/1ps
module tb_sqr_dds_gen;

    localparam int NCH = 2, ACC_W = 32, FREQ_W = 32, PHASE_W = 8, AMP_W = 8, DAC_W = 14;
    localparam logic [DAC_W-1:0] HI = 14'd16351, LO = 14'd33, MIDV = 14'd8192;
    localparam logic [15:0] PH = {8'd64, 8'd0};

    logic                   clk = 1'b0;
    logic                   rst_n, en, cfg_we;
    logic [FREQ_W-1:0]      freq;
    logic [PHASE_W-1:0]     duty;
    logic [AMP_W-1:0]       amp;
    logic [NCH*PHASE_W-1:0] phase;
    logic                   cfg_ack, sync;
    logic [NCH*DAC_W-1:0]   da_out;
    logic [DAC_W-1:0]       da0, da1;
    int                     n_pass = 0, n_total = 0;

    assign da0 = da_out[DAC_W-1:0];
    assign da1 = da_out[2*DAC_W-1:DAC_W];

    always #5 clk = ~clk;

    sqr_dds_gen #(
        .NCH(NCH), .ACC_W(ACC_W), .FREQ_W(FREQ_W),
        .PHASE_W(PHASE_W), .AMP_W(AMP_W), .DAC_W(DAC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we),
        .freq(freq), .duty(duty), .amp(amp), .phase(phase),
        .cfg_ack(cfg_ack), .sync(sync), .da_out(da_out)
    );

    function automatic logic [DAC_W-1:0] lvl(input int top, input int off, input int d);
        return (((top + off) % 256) < d) ? HI : LO;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [31:0] f, input logic [7:0] d, input logic [7:0] a,
                             input logic [15:0] p);
        freq = f; duty = d; amp = a; phase = p; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        $display("cfg write: freq=0x%08h duty=%0d amp=%0d phase=0x%04h", f, d, a, p);
    endtask

    task automatic settle();
`ifdef SQR_CFG_SHADOW_EN
        repeat (260) tick();
`else
        repeat (2) tick();
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; cfg_we = 1'b1;
        freq = 32'h0100_0000; duty = 8'd128; amp = 8'd255; phase = PH;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (da_out !== '0) $display("FAIL reset_da: got %0h, expected 0", da_out);
            else n_pass++;
            n_total++;
            if (sync !== 1'b0) $display("FAIL reset_sync: got %0b, expected 0", sync);
            else n_pass++;
            n_total++;
            if (cfg_ack !== 1'b0) $display("FAIL reset_ack: got %0b, expected 0", cfg_ack);
            else n_pass++;
        end
        cfg_we = 1'b0; en = 1'b0; rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_period();
        int rise0, rise1, n;
        logic [DAC_W-1:0] p0, p1, e0, e1;
        logic es;
        write_cfg(32'h0100_0000, 8'd128, 8'd255, PH);
`ifdef SQR_CFG_SHADOW_EN
        n_total++;
        if (cfg_ack !== 1'b0) $display("FAIL ack_wait: got %0b, expected 0", cfg_ack);
        else n_pass++;
        tick();
        n_total++;
        if (cfg_ack !== 1'b1) $display("FAIL ack_idle_copy: got %0b, expected 1", cfg_ack);
        else n_pass++;
`else
        n_total++;
        if (cfg_ack !== 1'b1) $display("FAIL ack_direct: got %0b, expected 1", cfg_ack);
        else n_pass++;
`endif
        tick();
        n_total++;
        if (cfg_ack !== 1'b0) $display("FAIL ack_single: got %0b, expected 0", cfg_ack);
        else n_pass++;
        en = 1'b1;
        tick();
        n_total++;
        if (da_out !== '0) $display("FAIL first_latency: got %0h, expected 0", da_out);
        else n_pass++;
        rise0 = -1; rise1 = -1; p0 = '0; p1 = '0;
        for (int t = 2; t <= 522; t++) begin
            tick();
            n  = t - 2;
            e0 = lvl(n, 0, 128);
            e1 = lvl(n, 64, 128);
            es = (n != 0) && (n % 256 == 0);
            n_total++;
            if (da0 !== e0) $display("FAIL period_ch0 n=%0d: got %0d, expected %0d", n, da0, e0);
            else n_pass++;
            n_total++;
            if (da1 !== e1) $display("FAIL period_ch1 n=%0d: got %0d, expected %0d", n, da1, e1);
            else n_pass++;
            n_total++;
            if (sync !== es) $display("FAIL period_sync n=%0d: got %0b, expected %0b", n, sync, es);
            else n_pass++;
            if (rise1 < 0 && p1 == LO && da1 == HI) rise1 = t;
            if (rise1 >= 0 && rise0 < 0 && p0 == LO && da0 == HI) rise0 = t;
            p0 = da0; p1 = da1;
        end
        n_total++;
        if (rise1 < 0 || rise0 < 0 || rise0 - rise1 != 64)
            $display("FAIL phase_lead: got %0d, expected 64", rise0 - rise1);
        else n_pass++;
        $display("period test done");
    endtask

    task automatic test_amp_duty();
        write_cfg(32'h0100_0000, 8'd128, 8'd0, PH);
`ifdef SQR_CFG_SHADOW_EN
        repeat (260) tick();
`else
        tick();
`endif
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (da0 !== MIDV) $display("FAIL amp0_ch0: got %0d, expected %0d", da0, MIDV);
            else n_pass++;
            n_total++;
            if (da1 !== MIDV) $display("FAIL amp0_ch1: got %0d, expected %0d", da1, MIDV);
            else n_pass++;
            tick();
        end
        write_cfg(32'h0100_0000, 8'd0, 8'd255, PH);
        settle();
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (da0 !== LO) $display("FAIL duty0_ch0: got %0d, expected %0d", da0, LO);
            else n_pass++;
            n_total++;
            if (da1 !== LO) $display("FAIL duty0_ch1: got %0d, expected %0d", da1, LO);
            else n_pass++;
            tick();
        end
        $display("amp/duty test done");
    endtask

    task automatic test_en_toggle();
        int n;
        logic [DAC_W-1:0] e0, e1;
        logic es;
        write_cfg(32'h0100_0000, 8'd128, 8'd255, PH);
        settle();
        repeat (37) tick();
        en = 1'b0;
        tick();
        n_total++;
        if (da_out !== '0) $display("FAIL en_off_da: got %0h, expected 0", da_out);
        else n_pass++;
        n_total++;
        if (sync !== 1'b0) $display("FAIL en_off_sync: got %0b, expected 0", sync);
        else n_pass++;
        write_cfg(32'h0200_0000, 8'd128, 8'd255, PH);
`ifdef SQR_CFG_SHADOW_EN
        tick();
`endif
        n_total++;
        if (cfg_ack !== 1'b1) $display("FAIL en_off_ack: got %0b, expected 1", cfg_ack);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (da_out !== '0) $display("FAIL en_off_hold: got %0h, expected 0", da_out);
        else n_pass++;
        en = 1'b1;
        tick();
        n_total++;
        if (da_out !== '0) $display("FAIL restart_latency: got %0h, expected 0", da_out);
        else n_pass++;
        for (int t = 2; t <= 201; t++) begin
            tick();
            n  = t - 2;
            e0 = lvl(2 * n, 0, 128);
            e1 = lvl(2 * n, 64, 128);
            es = (n != 0) && (n % 128 == 0);
            n_total++;
            if (da0 !== e0) $display("FAIL restart_ch0 n=%0d: got %0d, expected %0d", n, da0, e0);
            else n_pass++;
            n_total++;
            if (da1 !== e1) $display("FAIL restart_ch1 n=%0d: got %0d, expected %0d", n, da1, e1);
            else n_pass++;
            n_total++;
            if (sync !== es) $display("FAIL restart_sync n=%0d: got %0b, expected %0b", n, sync, es);
            else n_pass++;
        end
        $display("enable toggle test done");
    endtask

`ifdef SQR_CFG_SHADOW_EN
    task automatic test_shadow();
        int k, top;
        logic [DAC_W-1:0] e0;
        logic es, ea;
        en = 1'b0;
        write_cfg(32'h0100_0000, 8'd128, 8'd255, PH);
        repeat (2) tick();
        en = 1'b1;
        for (int t = 1; t <= 500; t++) begin
            if (t == 101) begin
                freq = 32'h0200_0000; cfg_we = 1'b1;
                $display("cfg write: freq=0x%08h (shadow, mid-period)", freq);
            end
            tick();
            cfg_we = 1'b0;
            ea = (t == 256);
            n_total++;
            if (cfg_ack !== ea) $display("FAIL shadow_ack t=%0d: got %0b, expected %0b", t, cfg_ack, ea);
            else n_pass++;
            if (t >= 3) begin
                k   = t - 2;
                top = (k <= 256) ? (k % 256) : ((2 * (k - 256)) % 256);
                e0  = lvl(top, 0, 128);
                es  = (k == 256) || (k == 384);
                n_total++;
                if (da0 !== e0) $display("FAIL shadow_ch0 t=%0d: got %0d, expected %0d", t, da0, e0);
                else n_pass++;
                n_total++;
                if (sync !== es) $display("FAIL shadow_sync t=%0d: got %0b, expected %0b", t, sync, es);
                else n_pass++;
            end
        end
        $display("shadow test done");
    endtask
`endif

    task automatic test_reset_mid();
        en = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (da_out !== '0) $display("FAIL midreset_da: got %0h, expected 0", da_out);
        else n_pass++;
        n_total++;
        if (sync !== 1'b0 || cfg_ack !== 1'b0)
            $display("FAIL midreset_flags: got sync=%0b ack=%0b, expected 0 0", sync, cfg_ack);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (da_out !== '0) $display("FAIL midreset_latency: got %0h, expected 0", da_out);
        else n_pass++;
        tick();
        n_total++;
        if (da0 !== MIDV || da1 !== MIDV)
            $display("FAIL midreset_cfg_cleared: got %0d/%0d, expected %0d", da0, da1, MIDV);
        else n_pass++;
        $display("mid-operation reset test done");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0;
        freq = '0; duty = '0; amp = '0; phase = '0;
        test_reset();
        test_period();
        test_amp_duty();
        test_en_toggle();
`ifdef SQR_CFG_SHADOW_EN
        test_shadow();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
